// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill count, almost flags, error pulses and optional first-word-fall-through
module sync_fifo #(
   parameter int data_width         = 16,
   parameter int fifo_depth_bits    = 4,
   parameter int almost_full_level  = 12,
   parameter int almost_empty_level = 2,
   parameter int fwft_mode          = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [data_width-1:0]    input_data,
   input  logic                     write_enable,
   input  logic                     read_enable,
   output logic [data_width-1:0]    output_data,
   output logic                     output_valid,
   output logic                     fifo_full,
   output logic                     fifo_empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [fifo_depth_bits:0] fill_count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int depth = 2 ** fifo_depth_bits;
   localparam logic [fifo_depth_bits:0] full_cnt = (fifo_depth_bits+1)'(depth);
   localparam logic [fifo_depth_bits:0] af_cnt = (fifo_depth_bits+1)'(almost_full_level);
   localparam logic [fifo_depth_bits:0] ae_cnt = (fifo_depth_bits+1)'(almost_empty_level);
   localparam bit fwft = fwft_mode != 0;

   logic [data_width-1:0] mem [depth];
   logic [fifo_depth_bits-1:0] wr_ptr, rd_ptr;
   logic wr_acc, rd_acc, ld, valid_nx;

   // flags and handshakes; in fwft mode the head register counts toward fill_count, so the array holds fill_count - output_valid words
   always_comb begin
      fifo_full    = fill_count == full_cnt;
      fifo_empty   = fwft ? !output_valid : fill_count == '0;
      almost_full  = fill_count >= af_cnt;
      almost_empty = fill_count <= ae_cnt;
      wr_acc       = write_enable && !fifo_full;
      rd_acc       = read_enable && !fifo_empty;
      ld           = fwft ? (!output_valid || rd_acc) && fill_count != {{fifo_depth_bits{1'b0}}, output_valid} : rd_acc;
      valid_nx     = fwft ? ld || (output_valid && !rd_acc) : rd_acc;
   end

   // storage array, deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= input_data;
   end

   // pointers, occupancy, output register and error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill_count   <= '0;
         output_data  <= '0;
         output_valid <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (ld) rd_ptr <= rd_ptr + 1'b1;
         if (ld) output_data <= mem[rd_ptr];
         if (wr_acc != rd_acc) fill_count <= wr_acc ? fill_count + 1'b1 : fill_count - 1'b1;
         output_valid <= valid_nx;
         overflow     <= write_enable && fifo_full;
         underflow    <= read_enable && fifo_empty;
      end
   end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that supersedes the dual-clock buffer in the SRAM controller datapath wherever producer and consumer share one clock. It adds full-depth capacity, asynchronous active-low reset, an occupancy count, programmable almost-full and almost-empty flags, overflow and underflow pulses, and a selectable first-word-fall-through read mode. It sits between the host command/data interface and the SRAM sequencer as the write-data and read-return buffer.

## Interface
- data_width, 16: word width in bits.
- fifo_depth_bits, 4: log2 of depth; DEPTH = 2**fifo_depth_bits.
- almost_full_level, 12: almost_full asserts when fill_count >= this; range 1..DEPTH.
- almost_empty_level, 2: almost_empty asserts when fill_count <= this; range 0..DEPTH-1.
- fwft_mode, 0: 0 = registered read (data one cycle after read_enable); 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock, reset is asynchronous and active-low.
- input_data  input  data_width  write word.
- write_enable  input  1  write request.
- read_enable  input  1  read request (fwft_mode=1: pop/acknowledge of head word).
- output_data  output  data_width  read word, registered.
- output_valid  output  1  output_data holds a valid word (see Operation).
- fifo_full  output  1  fill_count == DEPTH.
- fifo_empty  output  1  no word available to read.
- almost_full  output  1  fill_count >= almost_full_level.
- almost_empty  output  1  fill_count <= almost_empty_level.
- fill_count  output  fifo_depth_bits+1  words held, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write_enable while fifo_full.
- underflow  output  1  one-cycle pulse: read_enable while fifo_empty.

## Operation
- Storage: DEPTH-entry array; read and write pointers fifo_depth_bits wide, wrap modulo DEPTH. Full capacity is DEPTH words (no sacrificed slot); occupancy tracked by fill_count.
- Write accepted at an edge iff write_enable && !fifo_full, with fifo_full sampled before that edge. A write on full is dropped, pointer unchanged, overflow pulses.
- Read accepted iff read_enable && !fifo_empty. A read on empty is dropped, output_data is held, underflow pulses.
- Simultaneous accepted read and write: fill_count unchanged. On full: read accepted, write dropped (overflow). On empty: write accepted, read dropped (underflow).
- fwft_mode=0: accepted read loads output_data with the head word; output_valid is high the cycle after an accepted read, low otherwise. fifo_empty = (fill_count == 0).
- fwft_mode=1: internal head register prefetches from the array whenever it is empty and the array is non-empty. output_valid = head register loaded; output_data = head word while valid. fifo_empty = !output_valid. fill_count includes the head-register word; total capacity remains DEPTH. Accepted pop with array non-empty refills the head on the same edge (back-to-back pops sustain one word per cycle).
- fill_count: +1 on accepted write only, -1 on accepted read only, otherwise unchanged. Flags are combinational from registered fill_count/output_valid.

## Timing
- Reset (rst_n low, async): pointers 0, fill_count 0, output_data 0, output_valid 0, head register empty, overflow/underflow 0; so fifo_empty=1, fifo_full=0, almost_full=0, almost_empty=1. Array contents are not reset. Reset mid-operation discards all content; the first write after deassertion lands at address 0.
- Write-to-flag latency: fill_count and fifo_full/almost_* update on the edge that accepts the write.
- fwft_mode=0 read latency: read_enable at edge N, data valid after edge N.
- fwft_mode=1 latency: write into an empty FIFO at edge N; output_valid=1 after edge N+1 (fill_count=1 with fifo_empty=1 for that one cycle).
- overflow/underflow are registered: high for exactly the cycle after the offending edge.

## Test plan
- Defaults, mode 0: write 0x0000..0x000F -> fifo_full=1 at fill_count=16; 17th write drops, overflow pulses 1 cycle; read 16 -> data 0x0000..0x000F in order, then fifo_empty=1.
- Wrap-around: 40 words streamed with interleaved reads, occupancy kept at 5..9 -> in-order data, fill_count never off by one across pointer wrap.
- Simultaneous: read+write at fill_count 7 -> count stays 7; at full -> count 16 then 15 pending write drop, overflow=1; at empty -> count 1, underflow=1.
- Thresholds: fill from 0 to 16 -> almost_empty deasserts at count 3, almost_full asserts at count 12; reverse on drain.
- fwft_mode=1: write 0xA5A5 to empty at edge N -> output_valid=1, output_data=0xA5A5 after N+1; continuous pop of 8 words -> one word per cycle, no bubbles.
- Reset mid-operation at fill_count 9 -> all outputs at reset values immediately (async); next write then read returns that word.
